// File: rtl/pipelined_mac_limb_array_if.sv
// -----------------------------------------------------------------------------
// pipelined_mac_limb_array_if
//   Operand/result bundle for the limb-array multiply-add core.
//
//   Handshake: valid-only, no back-pressure. The source presents
//   a/b/c/acc_en/acc_first together with in_valid=1. The core takes the op on
//   any rising edge where its ce input is 1. On the result side, out_valid=1
//   means p carries a fresh result. While ce=0 both sides are frozen: inputs
//   are ignored, and out_valid/p keep their values.
//
//   Parameters
//     D_W  operand width (LIMB_W*NUM_LIMBS of the core)
//     P_W  result width (2*D_W + GUARD_W of the core)
//
//   Signals
//     in_valid   source -> core  op present this cycle
//     a, b, c    source -> core  unsigned operands, result = a*b + c
//     acc_en     source -> core  route the result through the accumulator
//     acc_first  source -> core  with acc_en: restart accumulation
//     out_valid  core -> sink    p holds a new result
//     p          core -> sink    result, modulo 2^P_W
// -----------------------------------------------------------------------------
interface pipelined_mac_limb_array_if #(
  parameter int D_W = 72,
  parameter int P_W = 152
);
  logic           in_valid;
  logic [D_W-1:0] a;
  logic [D_W-1:0] b;
  logic [D_W-1:0] c;
  logic           acc_en;
  logic           acc_first;
  logic           out_valid;
  logic [P_W-1:0] p;

  // Operand source / result sink side.
  modport master (
    output in_valid, a, b, c, acc_en, acc_first,
    input  out_valid, p
  );

  // The multiply-add core.
  modport slave (
    input  in_valid, a, b, c, acc_en, acc_first,
    output out_valid, p
  );
endinterface

// File: rtl/pipelined_mac_limb_array.sv
// -----------------------------------------------------------------------------
// pipelined_mac_limb_array
//   Computes a*b + c from a NUM_LIMBS x NUM_LIMBS array of LIMB_W-bit limb
//   products. Carry resolution is spread over registered stages. The core
//   also has an optional accumulator with GUARD_W extra MSBs. It takes one op
//   per ce-enabled cycle. The result appears NUM_LIMBS+2 ce-enabled edges
//   after the capture edge.
//
//   Pipeline (one register rank each, all gated by ce):
//     capture   limb products a[i]*b[j]; c limb j folded into row i=0
//     compress  products summed into 2*NUM_LIMBS column sums (carry-save)
//     ripple r  r = 0..NUM_LIMBS-1, resolves columns 2r and 2r+1 into final
//               limbs. The carry is registered into the next rank. Columns
//               already resolved ride along to stay aligned.
//     output    accumulate/select register driving out_valid and p
//
//   Ports
//     clk   in   clock, all state on the rising edge
//     rst   in   asynchronous reset, active-high
//     ce    in   clock enable; 0 freezes every register including acc
//     bus   slave modport of pipelined_mac_limb_array_if (operands in,
//           out_valid/p out)
// -----------------------------------------------------------------------------
module pipelined_mac_limb_array #(
  parameter int LIMB_W    = 18,
  parameter int NUM_LIMBS = 4,
  parameter int GUARD_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  pipelined_mac_limb_array_if.slave bus
);

  localparam int D_W = LIMB_W * NUM_LIMBS;
  localparam int P_W = 2 * D_W + GUARD_W;
  localparam int NC  = 2 * NUM_LIMBS;          // result columns, one limb each
  localparam int PW2 = 2 * LIMB_W;             // one limb product
  // A column collects at most NC limb-sized terms, and a carry adds a little
  // more. The extra bit keeps column sum plus carry-in from overflowing.
  localparam int CW  = LIMB_W + $clog2(NC) + 1;

  // ---------------------------------------------------------------------------
  // Control delay line: index 0 = capture rank, 1 = compress rank,
  // r+2 = ripple rank r. The top index feeds the output register.
  // ---------------------------------------------------------------------------
  logic [NUM_LIMBS+1:0] vld_q;
  logic [NUM_LIMBS+1:0] ace_q;
  logic [NUM_LIMBS+1:0] afst_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      ace_q  <= '0;
      afst_q <= '0;
    end else if (ce) begin
      vld_q  <= {vld_q[NUM_LIMBS:0],  bus.in_valid};
      ace_q  <= {ace_q[NUM_LIMBS:0],  bus.acc_en};
      afst_q <= {afst_q[NUM_LIMBS:0], bus.acc_first};
    end
  end

  // ---------------------------------------------------------------------------
  // Capture rank: limb products. Row i=0 also absorbs c limb j. The sum still
  // fits in 2*LIMB_W bits: (2^L-1)^2 + (2^L-1) = 2^2L - 2^L.
  // ---------------------------------------------------------------------------
  logic [PW2-1:0] prod_d [NUM_LIMBS][NUM_LIMBS];
  logic [PW2-1:0] prod_q [NUM_LIMBS][NUM_LIMBS];

  always_comb begin
    for (int i = 0; i < NUM_LIMBS; i++) begin
      for (int j = 0; j < NUM_LIMBS; j++) begin
        prod_d[i][j] = PW2'(bus.a[i*LIMB_W +: LIMB_W]) * PW2'(bus.b[j*LIMB_W +: LIMB_W])
                     + ((i == 0) ? PW2'(bus.c[j*LIMB_W +: LIMB_W]) : '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LIMBS; i++) begin
        for (int j = 0; j < NUM_LIMBS; j++) begin
          prod_q[i][j] <= '0;
        end
      end
    end else if (ce) begin
      prod_q <= prod_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Compress rank: product (i,j) puts its low half in column i+j and its high
  // half in column i+j+1. No carries move yet.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col_d [NC];
  logic [CW-1:0] col_q [NC];

  always_comb begin
    for (int k = 0; k < NC; k++) begin
      col_d[k] = '0;
    end
    for (int i = 0; i < NUM_LIMBS; i++) begin
      for (int j = 0; j < NUM_LIMBS; j++) begin
        col_d[i+j]   = col_d[i+j]   + CW'(prod_q[i][j][LIMB_W-1:0]);
        col_d[i+j+1] = col_d[i+j+1] + CW'(prod_q[i][j][PW2-1:LIMB_W]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NC; k++) begin
        col_q[k] <= '0;
      end
    end else if (ce) begin
      col_q <= col_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Ripple ranks. Rank r takes the carry from rank r-1, or zero for rank 0.
  // It folds the carry into columns 2r and 2r+1 in turn, keeping LIMB_W bits
  // per column. The leftover carry goes to the next rank. Each rank carries
  // the whole column vector so resolved low limbs stay aligned with the op.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] rip_d [NUM_LIMBS][NC];
  logic [CW-1:0] rip_q [NUM_LIMBS][NC];
  logic [CW-1:0] cry_d [NUM_LIMBS];
  logic [CW-1:0] cry_q [NUM_LIMBS];

  always_comb begin : ripple_comb
    logic [CW-1:0] cin;
    logic [CW-1:0] sum;
    cin = '0;
    sum = '0;
    // Rank inputs: rank 0 from the column sums, later ranks from the rank
    // before.
    for (int k = 0; k < NC; k++) begin
      rip_d[0][k] = col_q[k];
    end
    cry_d[0] = '0;
    for (int r = 1; r < NUM_LIMBS; r++) begin
      for (int k = 0; k < NC; k++) begin
        rip_d[r][k] = rip_q[r-1][k];
      end
      cry_d[r] = cry_q[r-1];
    end
    // Resolve this rank's two columns.
    for (int r = 0; r < NUM_LIMBS; r++) begin
      cin = cry_d[r];
      for (int h = 0; h < 2; h++) begin
        sum               = rip_d[r][2*r+h] + cin;
        rip_d[r][2*r+h]   = CW'(sum[LIMB_W-1:0]);
        cin               = sum >> LIMB_W;
      end
      cry_d[r] = cin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_LIMBS; r++) begin
        for (int k = 0; k < NC; k++) begin
          rip_q[r][k] <= '0;
        end
        cry_q[r] <= '0;
      end
    end else if (ce) begin
      rip_q <= rip_d;
      cry_q <= cry_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Assemble T = a*b + c from the fully resolved limbs. T < 2^(2*D_W), so the
  // last carry and the upper column bits are always zero.
  // ---------------------------------------------------------------------------
  logic [2*D_W-1:0] t_full;
  logic             unused_bits;

  always_comb begin
    t_full      = '0;
    unused_bits = ^cry_q[NUM_LIMBS-1];
    for (int k = 0; k < NC; k++) begin
      t_full[k*LIMB_W +: LIMB_W] = rip_q[NUM_LIMBS-1][k][LIMB_W-1:0];
      unused_bits = unused_bits ^ (^rip_q[NUM_LIMBS-1][k][CW-1:LIMB_W]);
    end
  end

  // ---------------------------------------------------------------------------
  // Output rank: accumulate/select. The accumulator updates on the same edge
  // that launches p. A back-to-back accumulate op therefore sees the new acc
  // with no forwarding stall. Plain ops leave acc untouched. The sum wraps
  // modulo 2^P_W by construction.
  // ---------------------------------------------------------------------------
  logic [P_W-1:0] t_ext;
  logic [P_W-1:0] acc_sum;
  logic [P_W-1:0] acc_d, acc_q;
  logic [P_W-1:0] p_d, p_q;
  logic           out_valid_d, out_valid_q;

  always_comb begin
    t_ext       = {{GUARD_W{1'b0}}, t_full};
    acc_sum     = acc_q + t_ext;
    acc_d       = acc_q;
    p_d         = p_q;
    out_valid_d = 1'b0;
    if (vld_q[NUM_LIMBS+1]) begin
      out_valid_d = 1'b1;
      if (ace_q[NUM_LIMBS+1]) begin
        acc_d = afst_q[NUM_LIMBS+1] ? t_ext : acc_sum;
        p_d   = acc_d;
      end else begin
        p_d   = t_ext;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (ce) begin
      acc_q       <= acc_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;

endmodule

// File: tb/tb_pipelined_mac_limb_array.sv
// -----------------------------------------------------------------------------
// tb_pipelined_mac_limb_array
//   Bench for pipelined_mac_limb_array at default parameters.
//   The reference model computes a*b+c with wide arithmetic and keeps the
//   accumulator in op order. Each result is queued with the ce-enabled edge
//   index at which it must appear.
// -----------------------------------------------------------------------------
module tb_pipelined_mac_limb_array;
  localparam int LIMB_W    = 18;
  localparam int NUM_LIMBS = 4;
  localparam int GUARD_W   = 8;
  localparam int D_W       = LIMB_W * NUM_LIMBS;
  localparam int P_W       = 2 * D_W + GUARD_W;
  localparam int LAT       = NUM_LIMBS + 2;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;
  always #5 clk = ~clk;

  pipelined_mac_limb_array_if #(.D_W(D_W), .P_W(P_W)) bus ();

  pipelined_mac_limb_array #(
    .LIMB_W   (LIMB_W),
    .NUM_LIMBS(NUM_LIMBS),
    .GUARD_W  (GUARD_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce (ce),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------- reference model
  logic [P_W-1:0] exp_q[$];
  int             due_q[$];
  logic           mdl_valid = 1'b0;
  logic [P_W-1:0] mdl_p     = '0;
  logic [P_W-1:0] mdl_acc   = '0;
  int             ce_cnt    = 0;

  initial begin : model
    logic [P_W-1:0] t;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        due_q.delete();
        mdl_valid = 1'b0;
        mdl_p     = '0;
        mdl_acc   = '0;
      end else if (ce) begin
        ce_cnt++;
        if (bus.in_valid) begin
          t = P_W'(bus.a) * P_W'(bus.b) + P_W'(bus.c);
          if (bus.acc_en) begin
            mdl_acc = bus.acc_first ? t : mdl_acc + t;
            exp_q.push_back(mdl_acc);
          end else begin
            exp_q.push_back(t);
          end
          due_q.push_back(ce_cnt + LAT);
        end
        if (due_q.size() != 0 && due_q[0] == ce_cnt) begin
          mdl_valid = 1'b1;
          mdl_p     = exp_q.pop_front();
          void'(due_q.pop_front());
        end else begin
          mdl_valid = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic drive_op(input logic [D_W-1:0] a, input logic [D_W-1:0] b,
                          input logic [D_W-1:0] c, input logic en, input logic fst);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.c         = c;
    bus.acc_en    = en;
    bus.acc_first = fst;
  endtask

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c         = '0;
    bus.acc_en    = 1'b0;
    bus.acc_first = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [D_W-1:0] rand_operand();
    logic [95:0] r;
    int          sel;
    sel = $urandom_range(0, 7);
    r   = {$urandom, $urandom, $urandom};
    case (sel)
      0:       return '1;
      1:       return '0;
      2:       return D_W'(r[7:0]);
      default: return r[D_W-1:0];
    endcase
  endfunction

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    ce  = 1'b1;
    drive_idle();
    repeat (2) step();
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid); end
    total++;
    if (bus.p !== '0) begin bad++; $display("FAIL reset_p got=%h want=0", bus.p); end
    rst = 1'b0;
    // One op through, so p is non-zero before the mid-stream reset.
    drive_op(72'd4, 72'd5, 72'd6, 1'b0, 1'b0);
    step();
    drive_idle();
    for (int k = 1; k <= LAT; k++) begin
      step();
      total++;
      if (bus.out_valid !== mdl_valid || bus.p !== mdl_p) begin
        bad++;
        $display("FAIL reset_pre k=%0d got v=%0b p=%h want v=%0b p=%h", k, bus.out_valid, bus.p, mdl_valid, mdl_p);
      end
    end
    total++;
    if (bus.p !== P_W'(26)) begin bad++; $display("FAIL reset_first_op got=%h want=1a", bus.p); end
    // Three ops in flight, then reset asserted between edges.
    for (int i = 0; i < 3; i++) begin
      drive_op(rand_operand(), rand_operand(), rand_operand(), 1'b1, (i == 0));
      step();
    end
    drive_idle();
    step();
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.p !== '0) begin
      bad++;
      $display("FAIL reset_async got v=%0b p=%h want v=0 p=0", bus.out_valid, bus.p);
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < LAT + 4; k++) begin
      step();
      total++;
      if (bus.out_valid !== 1'b0 || bus.p !== '0) begin
        bad++;
        $display("FAIL reset_flush k=%0d got v=%0b p=%h want v=0 p=0", k, bus.out_valid, bus.p);
      end
    end
  endtask

  task automatic test_max_operands();
    logic [P_W-1:0] want;
    want = (P_W'(1) << 144) - (P_W'(1) << 72);
    for (int k = 0; k <= LAT + 1; k++) begin
      if (k == 0) drive_op('1, '1, '1, 1'b0, 1'b0);
      else        drive_idle();
      step();
      total++;
      if (bus.out_valid !== (k == LAT)) begin
        bad++;
        $display("FAIL max_valid k=%0d got=%0b want=%0b", k, bus.out_valid, (k == LAT));
      end
      if (k >= LAT) begin
        total++;
        if (bus.p !== want) begin bad++; $display("FAIL max_p k=%0d got=%h want=%h", k, bus.p, want); end
      end
    end
  endtask

  task automatic test_accum_wrap();
    int             n_out;
    logic [P_W-1:0] p256, p257, w256, w257;
    n_out = 0;
    p256  = '0;
    p257  = '0;
    w256  = P_W'(0) - (P_W'(1) << 80);
    w257  = w256 + ((P_W'(1) << 144) - (P_W'(1) << 72));
    for (int i = 0; i < 257 + LAT + 2; i++) begin
      if (i < 257) drive_op('1, '1, '1, 1'b1, (i == 0));
      else         drive_idle();
      step();
      total++;
      if (bus.out_valid !== mdl_valid || bus.p !== mdl_p) begin
        bad++;
        $display("FAIL wrap_stream i=%0d got v=%0b p=%h want v=%0b p=%h", i, bus.out_valid, bus.p, mdl_valid, mdl_p);
      end
      if (bus.out_valid === 1'b1) begin
        n_out++;
        if (n_out == 256) p256 = bus.p;
        if (n_out == 257) p257 = bus.p;
      end
    end
    total++;
    if (n_out != 257) begin bad++; $display("FAIL wrap_count got=%0d want=257", n_out); end
    total++;
    if (p256 !== w256) begin bad++; $display("FAIL wrap_256 got=%h want=%h", p256, w256); end
    total++;
    if (p257 !== w257) begin bad++; $display("FAIL wrap_257 got=%h want=%h", p257, w257); end
  endtask

  task automatic test_stall();
    logic [P_W-1:0] held;
    held = mdl_p;
    // 3*5+7 with four ce=0 cycles injected two edges after capture.
    for (int k = 0; k <= 12; k++) begin
      if (k == 0) begin
        ce = 1'b1;
        drive_op(72'd3, 72'd5, 72'd7, 1'b0, 1'b0);
      end else if (k >= 3 && k <= 6) begin
        ce = 1'b0;
        drive_op(rand_operand(), rand_operand(), rand_operand(), 1'b1, 1'b1);
      end else begin
        ce = 1'b1;
        drive_idle();
      end
      step();
      total++;
      if (bus.out_valid !== (k == 10)) begin
        bad++;
        $display("FAIL stall_valid k=%0d got=%0b want=%0b", k, bus.out_valid, (k == 10));
      end
      total++;
      if (bus.p !== ((k >= 10) ? P_W'(22) : held)) begin
        bad++;
        $display("FAIL stall_p k=%0d got=%h want=%h", k, bus.p, ((k >= 10) ? P_W'(22) : held));
      end
    end
    // Stall while out_valid is high: the pulse and p must be held.
    for (int k = 0; k <= 10; k++) begin
      ce = !(k >= 7 && k <= 9);
      if (k == 0) drive_op(72'd2, 72'd3, 72'd4, 1'b0, 1'b1);
      else        drive_idle();
      step();
      total++;
      if (bus.out_valid !== (k >= 6 && k <= 9)) begin
        bad++;
        $display("FAIL stall_hold_valid k=%0d got=%0b want=%0b", k, bus.out_valid, (k >= 6 && k <= 9));
      end
      if (k >= 6) begin
        total++;
        if (bus.p !== P_W'(10)) begin bad++; $display("FAIL stall_hold_p k=%0d got=%h want=a", k, bus.p); end
      end
    end
    ce = 1'b1;
  endtask

  task automatic test_interleave();
    logic [P_W-1:0] want [4];
    want[0] = P_W'(1);
    want[1] = P_W'(5);
    want[2] = P_W'(82);
    want[3] = P_W'(14);
    for (int k = 0; k < LAT + 6; k++) begin
      case (k)
        0:       drive_op(72'd1, 72'd1, 72'd0, 1'b1, 1'b1);
        1:       drive_op(72'd2, 72'd2, 72'd0, 1'b1, 1'b0);
        2:       drive_op(72'd9, 72'd9, 72'd1, 1'b0, 1'b1);
        3:       drive_op(72'd3, 72'd3, 72'd0, 1'b1, 1'b0);
        default: drive_idle();
      endcase
      step();
      total++;
      if (bus.out_valid !== (k >= LAT && k < LAT + 4)) begin
        bad++;
        $display("FAIL inter_valid k=%0d got=%0b want=%0b", k, bus.out_valid, (k >= LAT && k < LAT + 4));
      end
      if (k >= LAT && k < LAT + 4) begin
        total++;
        if (bus.p !== want[k-LAT]) begin
          bad++;
          $display("FAIL inter_p k=%0d got=%h want=%h", k, bus.p, want[k-LAT]);
        end
      end
    end
  endtask

  task automatic test_random();
    int   n_cap;
    int   n_out;
    logic ce_now;
    n_cap = 0;
    n_out = 0;
    for (int i = 0; i < 6000 + LAT + 2; i++) begin
      if (i < 6000) begin
        ce_now = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 3) != 0)
          drive_op(rand_operand(), rand_operand(), rand_operand(),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        else
          drive_idle();
      end else begin
        ce_now = 1'b1;
        drive_idle();
      end
      ce = ce_now;
      if (ce_now && bus.in_valid) n_cap++;
      step();
      total++;
      if (bus.out_valid !== mdl_valid || bus.p !== mdl_p) begin
        bad++;
        $display("FAIL random i=%0d got v=%0b p=%h want v=%0b p=%h", i, bus.out_valid, bus.p, mdl_valid, mdl_p);
      end
      if (ce_now && bus.out_valid === 1'b1) n_out++;
    end
    total++;
    if (n_out != n_cap) begin bad++; $display("FAIL random_count got=%0d want=%0d", n_out, n_cap); end
    ce = 1'b1;
  endtask

  // ---------------------------------------------------------------- sequence + report
  initial begin
    drive_idle();
    test_reset();
    test_max_operands();
    test_accum_wrap();
    test_stall();
    test_interleave();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
